// File: rtl/port_tx_ctrl.sv
// port_tx_ctrl: packet egress controller reading a DA/SA/LEN/payload FIFO into a 2-entry buffer with sop/eop framing, inter-packet gap and packet counter
// Ports: clk/rst (async active-high); fifo_empty/fifo_rd_en/fifo_data (1-cycle read latency);
//        out_data/out_valid/out_ready/out_sop/out_eop egress stream; busy; pkt_cnt (eop transfers, wraps).
module port_tx_ctrl #(
  parameter int W_WIDTH = 8,
  parameter int IPG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [W_WIDTH-1:0] fifo_data,
  output logic [W_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic               busy,
  output logic [15:0]        pkt_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [3:0]         gap_q, gap_d;
  logic [8:0]         rd_idx_q, rd_idx_d, cap_idx_q, cap_idx_d, last;
  logic [7:0]         len_q, len_d, len_eff;
  logic [1:0]         occ_q, occ_d, occ_p;
  logic               inflight_q;
  logic [W_WIDTH+1:0] e0_q, e0_d, e1_q, e1_d, s0, new_e;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               pop, eop_xfer, more;
  always_comb begin
    out_valid  = occ_q != 2'd0;
    out_data   = e0_q[W_WIDTH-1:0];
    out_sop    = out_valid && e0_q[W_WIDTH+1];
    out_eop    = out_valid && e0_q[W_WIDTH];
    busy       = state_q != IDLE || out_valid;
    pkt_cnt    = pkt_cnt_q;
    pop        = out_valid && out_ready;
    eop_xfer   = pop && e0_q[W_WIDTH];
    // LEN is usable in the very cycle it returns so the read of byte 3 is not delayed
    len_eff    = (inflight_q && cap_idx_q == 9'd2) ? fifo_data[7:0] : len_q;
    last       = {1'b0, len_eff} + 9'd2;
    more       = rd_idx_q < 9'd3 || rd_idx_q <= last;
    // occupancy is taken after this cycle's pop, which sustains one byte per cycle
    fifo_rd_en = state_q == XFER && !fifo_empty && more &&
                 ({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    new_e      = {cap_idx_q == 9'd0, cap_idx_q >= 9'd2 && cap_idx_q == last, fifo_data};
    s0         = pop ? e1_q : e0_q;
    occ_p      = occ_q - {1'b0, pop};
    e0_d       = (inflight_q && occ_p == 2'd0) ? new_e : s0;
    e1_d       = (inflight_q && occ_p == 2'd1) ? new_e : e1_q;
    occ_d      = occ_p + {1'b0, inflight_q};
    len_d      = len_eff;
    rd_idx_d   = state_q == IDLE ? 9'd0 : rd_idx_q + {8'd0, fifo_rd_en};
    cap_idx_d  = state_q == IDLE ? 9'd0 : cap_idx_q + {8'd0, inflight_q};
    gap_d      = state_q == GAP ? gap_q + 4'd1 : 4'd0;
    pkt_cnt_d  = pkt_cnt_q + {15'd0, eop_xfer};
    state_d    = state_q == IDLE ? (fifo_empty ? IDLE : XFER) :
                 state_q == XFER ? (eop_xfer ? (IPG == 0 ? IDLE : GAP) : XFER) :
                 (gap_q == 4'(IPG - 1) ? IDLE : GAP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      rd_idx_q   <= '0;
      cap_idx_q  <= '0;
      len_q      <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      rd_idx_q   <= rd_idx_d;
      cap_idx_q  <= cap_idx_d;
      len_q      <= len_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end
endmodule

// File: tb/tb_port_tx_ctrl.sv
// tb_port_tx_ctrl: directed self-checking bench for port_tx_ctrl
module tb_port_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_empty = 1'b1;
  logic fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_sop, out_eop, busy;
  logic [15:0] pkt_cnt;
  int checks = 0, errors = 0, cyc = 0, rd_count = 0, force_cnt = 0, eop_seen = 0;
  logic [7:0] q[$];
  logic [7:0] rx_d[$], exp_d[$];
  bit rx_s[$], rx_e[$], exp_s[$], exp_e[$];
  int rx_t[$];
  bit was_stalled = 0;
  logic [10:0] prev_out;

  port_tx_ctrl #(.W_WIDTH(8), .IPG(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic rd;
    fifo_empty = (q.size() == 0) || (force_cnt > 0);
    #1;
    rd = fifo_rd_en;
    if (fifo_empty) begin
      checks++;
      if (rd !== 1'b0) begin errors++; $display("FAIL rd_while_empty cyc %0d got %b want 0", cyc, rd); end
    end
    if (was_stalled) begin
      checks++;
      if ({out_valid, out_data, out_sop, out_eop} !== prev_out) begin
        errors++; $display("FAIL stall_hold cyc %0d got %h want %h", cyc, {out_valid, out_data, out_sop, out_eop}, prev_out);
      end
    end
    if (dut.inflight_q) begin
      checks++;
      if (dut.occ_q == 2'd2 && !(out_valid && out_ready)) begin errors++; $display("FAIL overflow cyc %0d got occ 2 want <2", cyc); end
    end
    was_stalled = out_valid && !out_ready;
    prev_out = {out_valid, out_data, out_sop, out_eop};
    if (out_valid && out_ready) begin
      rx_d.push_back(out_data); rx_s.push_back(out_sop); rx_e.push_back(out_eop); rx_t.push_back(cyc);
      if (out_eop) eop_seen++;
    end
    if (rd) rd_count++;
    @(posedge clk);
    cyc++;
    #1;
    if (rd && q.size() > 0) fifo_data = q.pop_front();
    if (force_cnt > 0) force_cnt--;
  endtask

  task automatic add_pkt(input logic [7:0] p[$]);
    foreach (p[i]) begin
      q.push_back(p[i]); exp_d.push_back(p[i]);
      exp_s.push_back(i == 0); exp_e.push_back(i == p.size() - 1);
    end
  endtask

  task automatic clear_rx();
    rx_d.delete(); rx_s.delete(); rx_e.delete(); rx_t.delete();
    exp_d.delete(); exp_s.delete(); exp_e.delete();
    eop_seen = 0; rd_count = 0;
  endtask

  task automatic run_eops(input int n, input string name);
    int g = 0;
    while (eop_seen < n && g < 200) begin tick(); g++; end
    checks++;
    if (eop_seen < n) begin errors++; $display("FAIL %s_timeout got %0d eops want %0d", name, eop_seen, n); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({fifo_rd_en, out_valid, out_sop, out_eop, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {fifo_rd_en, out_valid, out_sop, out_eop, busy});
    end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++;
    if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", pkt_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_rx();
    out_ready = 1'b1;
    add_pkt('{8'h11, 8'h22, 8'h03, 8'hA1, 8'hA2, 8'hA3});
    run_eops(1, "single");
    checks++;
    if (rx_d.size() !== 6) begin errors++; $display("FAIL single_len got %0d want 6", rx_d.size()); end
    else foreach (exp_d[i]) begin
      checks++;
      if ({rx_d[i], rx_s[i], rx_e[i]} !== {exp_d[i], exp_s[i], exp_e[i]}) begin
        errors++; $display("FAIL single_byte%0d got %h/%b/%b want %h/%b/%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (rx_t.size() == 6 && rx_t[5] - rx_t[0] !== 5) begin errors++; $display("FAIL single_rate got %0d want 5", rx_t[5] - rx_t[0]); end
    checks++;
    if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", pkt_cnt); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy0 got %b want 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy1 got %b want 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL gap_end got %b want 0", busy); end
  endtask

  task automatic test_len0();
    clear_rx();
    out_ready = 1'b1;
    add_pkt('{8'h05, 8'h06, 8'h00});
    add_pkt('{8'h01, 8'h02, 8'h00});
    run_eops(1, "len0a");
    checks++;
    if (rd_count !== 3) begin errors++; $display("FAIL len0_reads got %0d want 3", rd_count); end
    run_eops(2, "len0b");
    checks++;
    if (rx_d.size() !== 6) begin errors++; $display("FAIL len0_len got %0d want 6", rx_d.size()); end
    else foreach (exp_d[i]) begin
      checks++;
      if ({rx_d[i], rx_s[i], rx_e[i]} !== {exp_d[i], exp_s[i], exp_e[i]}) begin
        errors++; $display("FAIL len0_byte%0d got %h/%b/%b want %h/%b/%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL len0_cnt got %0d want 3", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    clear_rx();
    add_pkt('{8'hA0, 8'hB0, 8'h02, 8'hC1, 8'hC2});
    add_pkt('{8'hA1, 8'hB1, 8'h01, 8'hD1});
    while (eop_seen < 2 && g < 300) begin out_ready = ~out_ready; tick(); g++; end
    checks++;
    if (eop_seen < 2) begin errors++; $display("FAIL b2b_timeout got %0d eops want 2", eop_seen); end
    out_ready = 1'b1;
    checks++;
    if (rx_d.size() !== 9) begin errors++; $display("FAIL b2b_len got %0d want 9", rx_d.size()); end
    else foreach (exp_d[i]) begin
      checks++;
      if ({rx_d[i], rx_s[i], rx_e[i]} !== {exp_d[i], exp_s[i], exp_e[i]}) begin
        errors++; $display("FAIL b2b_byte%0d got %h/%b/%b want %h/%b/%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL b2b_cnt got %0d want 5", pkt_cnt); end
  endtask

  task automatic test_empty_stall();
    int g = 0;
    bit forced = 0;
    clear_rx();
    out_ready = 1'b1;
    add_pkt('{8'h31, 8'h32, 8'h04, 8'h41, 8'h42, 8'h43, 8'h44});
    while (eop_seen < 1 && g < 200) begin
      if (rd_count == 4 && !forced) begin force_cnt = 5; forced = 1; end
      tick(); g++;
    end
    checks++;
    if (eop_seen < 1) begin errors++; $display("FAIL stall_timeout got %0d eops want 1", eop_seen); end
    checks++;
    if (rx_d.size() !== 7) begin errors++; $display("FAIL stall_len got %0d want 7", rx_d.size()); end
    else foreach (exp_d[i]) begin
      checks++;
      if ({rx_d[i], rx_s[i], rx_e[i]} !== {exp_d[i], exp_s[i], exp_e[i]}) begin
        errors++; $display("FAIL stall_byte%0d got %h/%b/%b want %h/%b/%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (rx_t.size() == 7 && rx_t[6] - rx_t[0] < 10) begin errors++; $display("FAIL stall_gap got %0d want >=10", rx_t[6] - rx_t[0]); end
    checks++;
    if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL stall_cnt got %0d want 6", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    clear_rx();
    out_ready = 1'b1;
    add_pkt('{8'h51, 8'h52, 8'h0A, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69});
    while (rx_d.size() < 5 && g < 100) begin tick(); g++; end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, out_valid, out_sop, out_eop, busy} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b want 00000", {fifo_rd_en, out_valid, out_sop, out_eop, busy});
    end
    checks++;
    if (out_data !== 8'h00 || pkt_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_vals got %h/%h want 00/0000", out_data, pkt_cnt); end
    q.delete();
    force_cnt = 0;
    was_stalled = 0;
    fifo_empty = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_rx();
    add_pkt('{8'h71, 8'h72, 8'h01, 8'h81});
    run_eops(1, "rstmid");
    checks++;
    if (rx_d.size() !== 4) begin errors++; $display("FAIL rstmid_len got %0d want 4", rx_d.size()); end
    else foreach (exp_d[i]) begin
      checks++;
      if ({rx_d[i], rx_s[i], rx_e[i]} !== {exp_d[i], exp_s[i], exp_e[i]}) begin
        errors++; $display("FAIL rstmid_byte%0d got %h/%b/%b want %h/%b/%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_wrap();
    repeat (4) tick();
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    checks++;
    if (pkt_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", pkt_cnt); end
    clear_rx();
    out_ready = 1'b1;
    add_pkt('{8'h05, 8'h06, 8'h00});
    run_eops(1, "wrap");
    checks++;
    if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt got %h want 0000", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len0();
    test_back_to_back();
    test_empty_stall();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_tx_ctrl.md
PORT_TX_CTRL -- requirements
Module: port_tx_ctrl

Interface
REQ-001 SHALL have parameter W_WIDTH, default 8, data byte width; must be 8 (packet length field is one byte).
REQ-002 SHALL have parameter IPG, default 2, idle cycles inserted after each packet's eop transfer, legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fifo_empty  input  1  upstream packet FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 SHALL have port fifo_data  input  W_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port out_data  output  W_WIDTH  egress byte.
REQ-009 SHALL have port out_valid  output  1  out_data/out_sop/out_eop valid.
REQ-010 SHALL have port out_ready  input  1  egress sink accepts; transfer = out_valid && out_ready.
REQ-011 SHALL have port out_sop  output  1  marks byte 0 (DA) of a packet.
REQ-012 SHALL have port out_eop  output  1  marks last byte of a packet.
REQ-013 SHALL have port busy  output  1  high when state != IDLE or buffer non-empty.
REQ-014 SHALL have port pkt_cnt  output  16  count of packets whose eop byte transferred, wraps at 2^16.

Function
REQ-015 Packet format: byte0 DA, byte1 SA, byte2 LEN (payload count 0..255), then LEN payload bytes; total LEN+3 bytes.
REQ-016 Internal 2-entry output buffer (data+sop+eop per entry) SHALL decouple 1-cycle FIFO read latency from out_ready backpressure.
REQ-017 fifo_rd_en SHALL assert only when !fifo_empty, state is XFER, (buffer occupancy + reads in flight) < 2, and the packet's eop byte has not yet been read.
REQ-018 Byte index counter SHALL advance on each fifo_data capture; index 0 tagged sop; index 2 captures LEN; eop tagged on index LEN+2 (index 2 itself when LEN=0).
REQ-019 FSM states IDLE, XFER, GAP; IDLE->XFER when !fifo_empty; XFER->GAP on transfer of an eop-tagged byte; GAP->IDLE after IPG cycles (IPG=0: GAP lasts 0 cycles, direct XFER->IDLE on eop transfer).
REQ-020 No FIFO read SHALL issue in GAP or IDLE; next packet's first read earliest the cycle after IDLE is entered with !fifo_empty.
REQ-021 out_data/out_sop/out_eop SHALL reflect the buffer head and SHALL hold stable while out_valid && !out_ready.
REQ-022 Sustained throughput SHALL be one byte per cycle within a packet when fifo_empty=0 and out_ready=1.
REQ-023 fifo_empty mid-packet SHALL stall reads; out_valid drops once the buffer drains; framing state is retained.
REQ-024 Simultaneous buffer push (read return) and pop (transfer) SHALL keep occupancy unchanged with no loss or reorder.
REQ-025 pkt_cnt SHALL increment by 1 on each eop transfer; 16'hFFFF wraps to 0.
REQ-026 Buffer SHALL never overflow; read return with buffer full is an illegal state (assertion in bench).

Reset
REQ-027 On rst assertion, asynchronously: state=IDLE, buffer and in-flight flags cleared, byte index=0, pkt_cnt=0, fifo_rd_en=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, busy=0.
REQ-028 Reset mid-packet SHALL discard the partial packet; a read in flight at reset is dropped; first action after release is a fresh IDLE->XFER.

Verification
REQ-029 Single packet DA=0x11 SA=0x22 LEN=3 payload 0xA1,0xA2,0xA3, out_ready=1 -> 6 bytes in order, sop on 0x11, eop on 0xA3, pkt_cnt=1, then IPG=2 idle cycles.
REQ-030 LEN=0 packet (0x05,0x06,0x00) -> 3 bytes, sop on 0x05, eop on 0x00, no further reads before GAP.
REQ-031 Two back-to-back packets, out_ready toggled 1/0 every cycle -> no byte lost/duplicated, outputs stable while stalled, pkt_cnt=2.
REQ-032 fifo_empty forced high for 5 cycles after byte index 3 -> no fifo_rd_en during empty, packet resumes intact with correct eop.
REQ-033 rst pulsed during payload byte 2 of a LEN=10 packet -> all outputs reset same cycle, pkt_cnt=0; next full packet transmitted correctly.
REQ-034 Preload pkt_cnt to 0xFFFF via 65535 LEN=0 packets (or force) then one more -> pkt_cnt=0x0000.
